// File: rtl/serial_parity_rx.sv
// serial_parity_rx: receive side of the XOR parity link.
// Deserialises start / DATA_W data bits (LSB first) / parity / stop frames,
// recomputes parity and reports parity and framing errors with each word.
module serial_parity_rx #(
  parameter int DATA_W     = 3,
  parameter int BAUD_DIV   = 4,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int HALF  = BAUD_DIV / 2;

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BAUD_M1  = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic             ODD_BIT  = (ODD_PARITY != 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    WAIT_HI = 3'd5
  } state_t;

  // Parity check: the XOR over data and received parity must equal the
  // configured sense (0 for even, 1 for odd); any other result is an error.
  function automatic logic parity_mismatch(input logic [DATA_W-1:0] data,
                                           input logic              par);
    return ((^data) ^ par) != ODD_BIT;
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_q, par_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                meta_q, sync_q;
  logic                rx_s;
  logic                sample_s;
  logic                half_s;

  assign rx_s = sync_q;

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rx_in;
      sync_q <= meta_q;
    end
  end

  assign sample_s = (cnt_q == BAUD_M1);
  assign half_s   = (cnt_q == HALF_M1);

  // Next-state logic: bit timing, shifting, and end-of-frame result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        // Mid-bit check of the start bit rejects short low glitches.
        if (half_s) begin
          cnt_d = '0;
          bit_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (sample_s) begin
          cnt_d   = '0;
          shift_d = (shift_q >> 1) | (DATA_W'(rx_s) << (DATA_W - 1));
          if (bit_q == LAST_BIT) begin
            state_d = PARITY;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (sample_s) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (sample_s) begin
          cnt_d   = '0;
          data_d  = shift_q;
          perr_d  = parity_mismatch(shift_q, par_q);
          ferr_d  = ~rx_s;
          valid_d = 1'b1;
          // A low stop bit means the line may be held low; wait for it to
          // recover so a break is never mistaken for a new start bit.
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT_HI;
          end
        end else begin
          state_d = STOP;
        end
      end
      WAIT_HI: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_HI;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

endmodule
